// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin share of the single write port
// between ALU and LSU, plus a pending-load scoreboard for decode hazards.
module rf_wb_arbiter #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [WORD_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [WORD_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  hazard_o,
  output logic                  busy_o,
  output logic [WORD_WIDTH-1:0] write_data_o,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic                  write_en_o
);

  logic                 prio_q;     // 1: LSU preferred on contention
  logic [REG_COUNT-1:0] pending_q;
  logic [REG_COUNT-1:0] pending_d;
  logic                 grant_alu;
  logic                 grant_lsu;

  // Grants are suppressed during reset so nothing is handshaken or written.
  always_comb begin
    grant_alu = rst_n && alu_valid_i && (!lsu_valid_i || !prio_q);
    grant_lsu = rst_n && lsu_valid_i && (!alu_valid_i ||  prio_q);
  end

  always_comb begin
    write_addr_o = '0;
    write_data_o = '0;
    if (grant_alu) begin
      write_addr_o = alu_addr_i;
      write_data_o = alu_data_i;
    end else if (grant_lsu) begin
      write_addr_o = lsu_addr_i;
      write_data_o = lsu_data_i;
    end
  end

  assign alu_ready_o = grant_alu;
  assign lsu_ready_o = grant_lsu;
  assign write_en_o  = (grant_alu || grant_lsu) && (write_addr_o != '0);

  // Clear is applied before set so a same-cycle issue to the register wins.
  always_comb begin
    pending_d = pending_q;
    if (grant_lsu)
      pending_d[lsu_addr_i] = 1'b0;
    if (issue_valid_i && issue_addr_i != '0)
      pending_d[issue_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b1;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (grant_alu)      prio_q <= 1'b1;
      else if (grant_lsu) prio_q <= 1'b0;
    end
  end

  // Hazard looks only at registered state; a same-cycle LSU clear costs a stall.
  always_comb begin
    hazard_o = rst_n && (
                 (pending_q[rs1_addr_i] && rs1_addr_i != '0) ||
                 (pending_q[rs2_addr_i] && rs2_addr_i != '0) ||
                 (pending_q[rd_addr_i]  && rd_addr_i  != '0));
    busy_o   = rst_n && (|pending_q);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter against a set-based reference model.
module tb_rf_wb_arbiter;
  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk, rst_n;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] alu_addr, lsu_addr, issue_addr, rs1_addr, rs2_addr, rd_addr, write_addr;
  logic [W-1:0]  alu_data, lsu_data, write_data;
  logic          issue_valid, hazard, busy, write_en;

  rf_wb_arbiter #(.WORD_WIDTH(W), .REG_COUNT(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .issue_valid_i(issue_valid), .issue_addr_i(issue_addr),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rd_addr_i(rd_addr),
    .hazard_o(hazard), .busy_o(busy),
    .write_data_o(write_data), .write_addr_o(write_addr), .write_en_o(write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       ar, lr, we, hz, bz;
    bit [4:0] wa;
    bit [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  // Reference model: pending loads as a plain set, preference as "who goes next".
  bit   pend[N];
  bit   lsu_next;
  bit   g_a, g_l;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (alu_ready !== e.ar || lsu_ready !== e.lr || write_en !== e.we ||
          write_addr !== e.wa || write_data !== e.wd || hazard !== e.hz || busy !== e.bz) begin
        errors++;
        $display("FAIL vec%0d: got ar=%0b lr=%0b we=%0b wa=%0d wd=%h hz=%0b bz=%0b want ar=%0b lr=%0b we=%0b wa=%0d wd=%h hz=%0b bz=%0b",
                 vectors, alu_ready, lsu_ready, write_en, write_addr, write_data, hazard, busy,
                 e.ar, e.lr, e.we, e.wa, e.wd, e.hz, e.bz);
      end
    end
  end

  task automatic step(input bit r, input bit av, input int aa, input int unsigned ad,
                      input bit lv, input int la, input int unsigned ld,
                      input bit iv, input int ia, input int s1, input int s2, input int sd);
    exp_t e;
    int   win; // 0 none, 1 alu, 2 lsu
    @(posedge clk); #1;
    cyc++;
    rst_n = r; alu_valid = av; alu_addr = AW'(aa); alu_data = ad;
    lsu_valid = lv; lsu_addr = AW'(la); lsu_data = ld;
    issue_valid = iv; issue_addr = AW'(ia);
    rs1_addr = AW'(s1); rs2_addr = AW'(s2); rd_addr = AW'(sd);
    e = '{default: 0};
    g_a = 0; g_l = 0;
    if (!r) begin
      lsu_next = 1;
      foreach (pend[i]) pend[i] = 0;
      exp_q.push_back(e);
      return;
    end
    win = 0;
    if (av && lv) win = lsu_next ? 2 : 1;
    else if (av)  win = 1;
    else if (lv)  win = 2;
    if (win == 1) begin e.ar = 1; e.wa = 5'(aa); e.wd = ad; end
    if (win == 2) begin e.lr = 1; e.wa = 5'(la); e.wd = ld; end
    e.we = (win != 0) && (e.wa != 0);
    e.hz = (s1 != 0 && pend[s1]) || (s2 != 0 && pend[s2]) || (sd != 0 && pend[sd]);
    foreach (pend[i]) if (pend[i]) e.bz = 1;
    exp_q.push_back(e);
    // state after the coming edge
    if (win == 1) begin lsu_next = 1; g_a = 1; end
    if (win == 2) begin lsu_next = 0; g_l = 1; pend[la] = 0; end
    if (iv && ia != 0) pend[ia] = 1;
  endtask

  initial begin
    bit ra_v, rl_v, rst_now;
    int ra_a, rl_a;
    int unsigned ra_d, rl_d;
    rst_n = 0; alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_addr = 0; lsu_addr = 0; issue_addr = 0; alu_data = 0; lsu_data = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    lsu_next = 1;
    // reset forces handshakes and status low even with requests present
    step(0, 1, 5, 32'h11, 1, 6, 32'h22, 1, 7, 7, 0, 0);
    step(0, 1, 5, 32'h11, 1, 6, 32'h22, 1, 7, 7, 0, 0);
    // ALU alone
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // contention straight after reset: LSU, ALU, LSU, ALU
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 1, 10, 32'hA0A0_0000 + i, 1, 11, 32'hB0B0_0000 + i, 0, 0, 0, 0, 0);
    // LSU to x0: accepted, no write, prio still flips to ALU
    step(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    step(1, 1, 12, 32'hC1, 1, 13, 32'hD1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 13, 32'hD1, 0, 0, 0, 0, 0);
    // x7 load: hazard until the cycle after the LSU accept
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    // same-cycle issue and accept to x9: set wins
    step(1, 0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    step(1, 0, 0, 0, 1, 9, 32'h9A, 0, 0, 0, 0, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    // mid-operation reset drops pending loads and restores LSU preference
    step(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 1, 2, 32'h2, 0, 0, 0, 1, 4, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0);
    step(1, 1, 20, 32'hE0, 1, 21, 32'hF0, 0, 0, 3, 4, 0);
    step(1, 1, 20, 32'hE0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random phase; unaccepted requests are held stable
    ra_v = 0; rl_v = 0; ra_a = 0; rl_a = 0; ra_d = 0; rl_d = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_now = ($urandom_range(0, 199) == 0);
      if (rst_now) begin ra_v = 0; rl_v = 0; end
      if (!ra_v || g_a) begin
        ra_v = $urandom_range(0, 2) != 0; ra_a = $urandom_range(0, 7); ra_d = $urandom;
      end
      if (!rl_v || g_l) begin
        rl_v = $urandom_range(0, 2) != 0; rl_a = $urandom_range(0, 7); rl_d = $urandom;
      end
      step(!rst_now, ra_v, ra_a, ra_d, rl_v, rl_a, rl_d,
           $urandom_range(0, 2) == 0, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if (rst_now) begin ra_v = 0; rl_v = 0; end
    end

    @(negedge clk); @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
